// File: rtl/load_store_unit.sv
// Load/store initiator for a word-organised data memory: RV32I funct3 decode,
// alignment/range checking, sub-word stores via read-modify-write.
module load_store_unit #(
    parameter int MEM_SIZE = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_SIZE * 4);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic        err_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] wword_q;
    logic        accept;

    function automatic logic req_error(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr);
        logic illegal, misaligned;
        illegal    = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        misaligned = (f3[1:0] == 2'b01 && addr[0]) ||
                     (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        return illegal || misaligned || (addr >= ADDR_LIMIT);
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic        [31:0] shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        shifted = word >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = shifted[15:0];
        case (f3)
            3'd0:    ext = b;  // signed-to-signed assignment sign-extends
            3'd1:    ext = h;
            3'd4:    ext = {24'd0, shifted[7:0]};
            3'd5:    ext = {16'd0, shifted[15:0]};
            default: ext = word;
        endcase
        return ext;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [4:0]  sh;
        logic [31:0] mask;
        sh = {lane, 3'b000};
        case (f3[1:0])
            2'b00:   mask = 32'h0000_00FF << sh;
            2'b01:   mask = 32'h0000_FFFF << sh;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (word & ~mask) | ((wdata << sh) & mask);
    endfunction

    assign accept = (state_q == IDLE) && req_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_error(req_we, req_funct3, req_addr) ? RESP : READ;
            READ:    state_d = we_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request latch: control fields reset, mem_addr must read 0 after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= '0;
        end else if (accept) begin
            we_q   <= req_we;
            err_q  <= req_error(req_we, req_funct3, req_addr);
            addr_q <= req_addr;
        end
    end

    // Data path: payload, load result and merged store word
    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
        end else if (state_q == READ) begin
            if (we_q) wword_q <= store_merge(mem_rd_data, wdata_q, funct3_q, addr_q[1:0]);
            else      rdata_q <= load_extend(mem_rd_data, funct3_q, addr_q[1:0]);
        end
    end

    assign req_ready   = (state_q == IDLE) && !rst;
    assign mem_addr    = {addr_q[31:2], 2'b00};
    assign mem_wr_en   = (state_q == WRITE) && !rst;
    assign mem_wr_data = (state_q == WRITE) ? wword_q : 32'd0;
    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = (state_q == RESP) ? rdata_q : 32'd0;
    assign resp_err    = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference memory, directed cases
// followed by randomized loads/stores.
module tb_load_store_unit;

    localparam int MEM_SIZE = 512;
    localparam int AW = $clog2(MEM_SIZE);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    logic [31:0] mem [MEM_SIZE];
    logic        init_en = 1'b0;
    logic [7:0]  ref_bytes [MEM_SIZE*4];

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
    endfunction

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= init_val(i);
        end else if (mem_wr_en && mem_addr[31:2] < 30'(MEM_SIZE)) begin
            mem[mem_addr[AW+1:2]] <= mem_wr_data;
        end
    end

    assign mem_rd_data = (mem_addr[31:2] < 30'(MEM_SIZE)) ? mem[mem_addr[AW+1:2]] : 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int base);
        return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] got, output logic got_err);
        int n, lat, ai, base;
        logic ill, mis, oor, err;
        logic [31:0] mask, exp_rd, exp_wword;
        int fsel;
        fsel = int'(f3) % 4;
        n = (fsel == 0) ? 1 : (fsel == 1) ? 2 : 4;
        ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis = (n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0);
        oor = addr >= 32'(MEM_SIZE * 4);
        err = ill || mis || oor;
        lat = err ? 1 : (we ? 3 : 2);
        exp_rd = 32'd0;
        exp_wword = 32'd0;
        if (!err) begin
            ai = int'(addr[AW+1:0]);
            base = ai - (ai % 4);
            mask = (n == 1) ? 32'hFF : (n == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
            if (we) begin
                for (int j = 0; j < n; j++) ref_bytes[ai + j] = 8'((wd >> (8 * j)) & 32'hFF);
                exp_wword = ref_word(base);
            end else begin
                for (int j = 0; j < n; j++) exp_rd = exp_rd | (32'(ref_bytes[ai + j]) << (8 * j));
                if (f3 < 3'd4 && n < 4 && exp_rd > (mask >> 1)) exp_rd = exp_rd | ~mask;
            end
        end
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        got = 32'd0;
        got_err = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(k == lat));
            chk({tag, ".wr_en"}, 32'(mem_wr_en), 32'(!err && we && k == 2));
            chk({tag, ".wr_data"}, mem_wr_data, (!err && we && k == 2) ? exp_wword : 32'd0);
            chk({tag, ".busy"}, 32'(req_ready), 32'd0);
            if (k == 1) chk({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
            if (k == lat) begin
                got = resp_rdata;
                got_err = resp_err;
                chk({tag, ".rdata"}, resp_rdata, exp_rd);
                chk({tag, ".err"}, 32'(resp_err), 32'(err));
            end
        end
        @(negedge clk);
        chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
        chk({tag, ".resp_low"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic        gerr;
        logic [31:0] expw;
        int          acc;
        logic [31:0] a;
        int          r;

        for (int i = 0; i < MEM_SIZE; i++)
            for (int j = 0; j < 4; j++) ref_bytes[4*i + j] = 8'(init_val(i) >> (8 * j));

        rst = 1'b1;
        init_en = 1'b1;
        @(posedge clk);
        #1 init_en = 1'b0;
        @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.ready_rel", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.wr_data", mem_wr_data, 32'd0);

        do_req("sw10", 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, got, gerr);
        do_req("lw10", 1'b0, 3'd2, 32'h10, 32'd0, got, gerr);
        chk("lw10.const", got, 32'hDEAD_BEEF);
        do_req("lb13", 1'b0, 3'd0, 32'h13, 32'd0, got, gerr);
        chk("lb13.const", got, 32'hFFFF_FFDE);
        do_req("lbu13", 1'b0, 3'd4, 32'h13, 32'd0, got, gerr);
        chk("lbu13.const", got, 32'h0000_00DE);
        do_req("lh12", 1'b0, 3'd1, 32'h12, 32'd0, got, gerr);
        chk("lh12.const", got, 32'hFFFF_DEAD);
        do_req("lhu10", 1'b0, 3'd5, 32'h10, 32'd0, got, gerr);
        chk("lhu10.const", got, 32'h0000_BEEF);
        do_req("sb11", 1'b1, 3'd0, 32'h11, 32'h1234_56AA, got, gerr);
        do_req("sh12", 1'b1, 3'd1, 32'h12, 32'h0000_1234, got, gerr);
        do_req("lw10b", 1'b0, 3'd2, 32'h10, 32'd0, got, gerr);
        chk("lw10b.const", got, 32'h1234_AAEF);

        do_req("lw12_mis", 1'b0, 3'd2, 32'h12, 32'd0, got, gerr);
        chk("lw12_mis.const", 32'(gerr), 32'd1);
        do_req("sh11_mis", 1'b1, 3'd1, 32'h11, 32'h5555, got, gerr);
        chk("sh11_mis.const", 32'(gerr), 32'd1);
        do_req("sw800_oor", 1'b1, 3'd2, 32'h800, 32'h1111_2222, got, gerr);
        chk("sw800_oor.const", 32'(gerr), 32'd1);
        do_req("ld_f3_ill", 1'b0, 3'd3, 32'h10, 32'd0, got, gerr);
        chk("ld_f3_ill.const", 32'(gerr), 32'd1);
        do_req("lw_last", 1'b0, 3'd2, 32'h7FC, 32'd0, got, gerr);

        // Held request: back-to-back LWs accepted once every 3 cycles
        expw = ref_word(32'h10);
        acc = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            chk("b2b.ready", 32'(req_ready), 32'(i % 3 == 0));
            chk("b2b.resp", 32'(resp_valid), 32'(i % 3 == 2));
            if (i % 3 == 2) chk("b2b.rdata", resp_rdata, expw);
            if (req_ready) acc++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b.last_resp", 32'(resp_valid), 32'd1);
        chk("b2b.last_rdata", resp_rdata, expw);
        @(negedge clk);
        chk("b2b.accepts", 32'(acc), 32'd4);

        // Reset during the WRITE cycle of a byte store
        expw = ref_word(32'h10);
        chk("rstw.ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'hFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstw.wr_en", 32'(mem_wr_en), 32'd0);
        chk("rstw.ready", 32'(req_ready), 32'd0);
        chk("rstw.resp", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstw.ready_after", 32'(req_ready), 32'd1);
        chk("rstw.no_resp", 32'(resp_valid), 32'd0);
        chk("rstw.mem", mem[4], expw);
        do_req("rstw.lw", 1'b0, 3'd2, 32'h10, 32'd0, got, gerr);
        chk("rstw.lw_const", got, expw);

        for (int t = 0; t < 200; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(MEM_SIZE * 4 - 4) + 32'($urandom_range(0, 7));
            else             a = 32'($urandom_range(0, 63));
            do_req("rnd", 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, got, gerr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

- Core-side initiator for the word-organised data memory.
- Accepts one load or store per request from the execute stage and decodes RV32I funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Sub-word stores are performed as read-modify-write, because the memory has only a full-word write enable and a combinational word read.
- Checks alignment and range, and returns sign- or zero-extended load data through a single-cycle response pulse.

## Interface

- MEM_SIZE, default 512: memory depth in 32-bit words; valid byte addresses are 0 .. MEM_SIZE*4-1.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; sampled only when req_ready=1.
- req_ready  out  1  unit idle and able to accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; misaligned, out-of-range or illegal funct3.
- mem_addr  out  32  byte address to memory, always word-aligned ({addr[31:2],2'b00}).
- mem_wr_en  out  1  memory write strobe.
- mem_wr_data  out  32  full merged word to write.
- mem_rd_data  in  32  combinational read data for mem_addr, valid in the same cycle.

## Operation

- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr and wdata, then check the request.
  - Error if any of: funct3 illegal (loads: 3,6,7; stores: 3..7); halfword with addr[0]=1; word with addr[1:0]!=0; addr >= MEM_SIZE*4 (32-bit unsigned compare).
  - On error go to RESP with err_q=1; memory is never touched. Otherwise go to READ.
- READ:
  - mem_addr = aligned address; mem_wr_en=0.
  - Load: extract the byte or halfword selected by addr[1:0] (little-endian: byte k = bits 8k+7:8k). Sign-extend for LB/LH, zero-extend for LBU/LHU, pass LW through. Register the result as rdata_q, then go to RESP.
  - Store: merge req_wdata[7:0], [15:0] or [31:0] into mem_rd_data at the selected lane, keeping the other bytes. Register the merged word, then go to WRITE. SW also passes through READ, so store latency is uniform.
- WRITE:
  - mem_wr_en=1 and mem_wr_data = merged word; the write commits at the closing edge.
  - Then go to RESP.
- RESP:
  - resp_valid=1, resp_rdata=rdata_q (0 for stores and errors), resp_err=err_q.
  - Next state is IDLE.
- While not in IDLE: req_ready=0 and req_valid is ignored. A held request is accepted only once req_ready returns to 1.
- mem_wr_data = 0 outside WRITE. mem_addr holds the latched aligned address in all states; it is 0 after reset.

## Timing

- Request accepted at cycle T (IDLE with req_valid=1).
- Load response: resp_valid at T+2.
- Store: write strobe at T+2, response at T+3.
- Error response: resp_valid at T+1; mem_wr_en stays 0 throughout.
- req_ready returns to 1 in the cycle after resp_valid. Maximum throughput is one load per 3 cycles and one store per 4 cycles.
- Reset values:
  - state=IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_wr_en=0, mem_addr=0, mem_wr_data=0.
  - req_ready=0 during any cycle with rst=1.
- Reset mid-operation: mem_wr_en is combinationally gated by !rst. Asserting rst during WRITE commits no write. The in-flight request is dropped without a response.
- A store followed by a load to the same word returns the new data, because the write commits before the load's READ cycle.

## Test plan

- SW 0xDEADBEEF @0x10, then LW @0x10: store response at T+3 with mem_wr_en high exactly at T+2; load returns 0xDEADBEEF at T+2 with resp_err=0.
- LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SB 0x123456AA @0x11, then SH 0x00001234 @0x12, then LW @0x10 -> 0x1234AAEF (other bytes preserved).
- Each of the following gives resp_err=1 at T+1 and resp_rdata=0, with no mem_wr_en pulse:
  - LW @0x12 (misaligned word);
  - SH @0x11 (misaligned halfword);
  - SW @0x800 (out of range, MEM_SIZE=512);
  - funct3=3 load (illegal).
- Hold req_valid high for 10 cycles with back-to-back LWs: exactly one acceptance per 3 cycles, with req_ready low while busy.
- Assert rst during the WRITE cycle of SB 0xFF @0x10: mem_wr_en=0 in that cycle, the word at 0x10 is unchanged, there is no resp_valid, and req_ready=1 in the first cycle after rst deasserts.
